// File: rtl/sleep_fsm_pkg.sv
// Shared state, input and output code definitions for the timed sleep FSM.
package sleep_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'b000,
        ST_NAP         = 3'b001,
        ST_SLEEP       = 3'b010,
        ST_HIBERNATE   = 3'b011,
        ST_WAKEUP      = 3'b100,
        ST_ATTENDCLASS = 3'b101
    } state_t;

    localparam logic [2:0] IN_GETTIRED     = 3'b001;
    localparam logic [2:0] IN_GETVERYTIRED = 3'b010;
    localparam logic [2:0] IN_TRANQUILIZER = 3'b011;
    localparam logic [2:0] IN_TIMEFORCLASS = 3'b100;
    localparam logic [2:0] IN_LOUDNOISE    = 3'b101;
    localparam logic [2:0] IN_ALARMCLOCK   = 3'b110;
    localparam logic [2:0] IN_COLDWATER    = 3'b111;

    localparam logic [5:0] OUT_IDLE   = 6'b100000;
    localparam logic [5:0] OUT_REST   = 6'b100001;
    localparam logic [5:0] OUT_WAKEUP = 6'b100010;
    localparam logic [5:0] OUT_CLASS  = 6'b100011;

    function automatic logic [5:0] out_code(input state_t s);
        case (s)
            ST_NAP, ST_SLEEP, ST_HIBERNATE: return OUT_REST;
            ST_WAKEUP:                      return OUT_WAKEUP;
            ST_ATTENDCLASS:                 return OUT_CLASS;
            default:                        return OUT_IDLE;
        endcase
    endfunction

    // Only the loud wake-ups count toward leaving SLEEP; TIMEFORCLASS does not.
    function automatic logic is_alarm_code(input logic [2:0] c);
        return (c == IN_LOUDNOISE) || (c == IN_ALARMCLOCK) || (c == IN_COLDWATER);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell-time counter: synchronous clear, count enable, terminal-count compare.
module dwell_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/sleep_fsm_timed.sv
// Sleep-state FSM with NAP/SLEEP timeouts, debounced SLEEP wake and wake counter.
module sleep_fsm_timed
    import sleep_fsm_pkg::*;
#(
    parameter int INPUT_SIZE    = 3,
    parameter int OUTPUT_SIZE   = 6,
    parameter int NAP_CYCLES    = 8,
    parameter int SLEEP_CYCLES  = 32,
    parameter int WAKE_DEBOUNCE = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_SIZE-1:0]  input_signal,
    input  logic                   input_valid,
    output logic [OUTPUT_SIZE-1:0] output_signal,
    output logic [2:0]             state_out,
    output logic                   timer_expired,
    output logic [7:0]             wake_count
);

    localparam int TW = (SLEEP_CYCLES > 2) ? $clog2(SLEEP_CYCLES) : 1;
    localparam int DW = $clog2(WAKE_DEBOUNCE + 1);
    localparam logic [TW-1:0] NAP_LAST   = TW'(NAP_CYCLES - 1);
    localparam logic [TW-1:0] SLEEP_LAST = TW'(SLEEP_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(WAKE_DEBOUNCE - 1);

    state_t          state, next_state, rest_target;
    logic [2:0]      code;
    logic            timeout_wake, sleep_alarm;
    logic [TW-1:0]   timer_count, timer_last;
    logic            timer_hit;
    logic [DW-1:0]   deb_cnt;

    assign code        = input_signal[2:0];
    assign sleep_alarm = input_valid && is_alarm_code(code);
    assign timer_last  = (state == ST_SLEEP) ? SLEEP_LAST : NAP_LAST;

    dwell_timer #(.WIDTH(TW)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (next_state != state),
        .enable      ((state == ST_NAP) || (state == ST_SLEEP)),
        .terminal    (timer_last),
        .count       (timer_count),
        .at_terminal (timer_hit)
    );

    // Shared IDLE/ATTENDCLASS decode; unlisted codes fall back to IDLE.
    always_comb begin
        rest_target = ST_IDLE;
        case (code)
            IN_GETTIRED:     rest_target = ST_NAP;
            IN_GETVERYTIRED: rest_target = ST_SLEEP;
            IN_TRANQUILIZER: rest_target = ST_HIBERNATE;
            IN_TIMEFORCLASS: rest_target = ST_ATTENDCLASS;
            default:         rest_target = ST_IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state   = state;
        timeout_wake = 1'b0;
        case (state)
            ST_IDLE, ST_ATTENDCLASS: begin
                if (input_valid) next_state = rest_target;
            end
            ST_NAP: begin
                if (input_valid && code[2]) begin
                    next_state = ST_WAKEUP;
                end else if (timer_hit) begin
                    next_state   = ST_WAKEUP;
                    timeout_wake = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (sleep_alarm && (deb_cnt == DEB_LAST)) begin
                    next_state = ST_WAKEUP;
                end else if (timer_hit) begin
                    next_state   = ST_WAKEUP;
                    timeout_wake = 1'b1;
                end
            end
            ST_HIBERNATE: begin
                if (input_valid && (code == IN_COLDWATER)) next_state = ST_WAKEUP;
            end
            ST_WAKEUP: begin
                next_state = (input_valid && (code == IN_TIMEFORCLASS)) ? ST_ATTENDCLASS : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            output_signal <= OUTPUT_SIZE'(OUT_IDLE);
            timer_expired <= 1'b0;
            wake_count    <= 8'd0;
            deb_cnt       <= '0;
        end else begin
            state         <= next_state;
            output_signal <= OUTPUT_SIZE'(out_code(next_state));
            timer_expired <= timeout_wake;
            if ((next_state == ST_WAKEUP) && (state != ST_WAKEUP) && (wake_count != 8'hFF))
                wake_count <= wake_count + 8'd1;
            if ((state == ST_SLEEP) && (next_state == ST_SLEEP) && sleep_alarm)
                deb_cnt <= deb_cnt + 1'b1;
            else
                deb_cnt <= '0;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_sleep_fsm_timed.sv
// Directed vector table plus hand-written timeout, debounce and reset sequences.
module tb_sleep_fsm_timed;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] input_signal;
    logic       input_valid;
    logic [5:0] output_signal;
    logic [2:0] state_out;
    logic       timer_expired;
    logic [7:0] wake_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_NAP = 3'd1, S_SLEEP = 3'd2,
                           S_HIB = 3'd3, S_WAKE = 3'd4, S_CLASS = 3'd5;
    localparam logic [5:0] O_IDLE = 6'h20, O_REST = 6'h21, O_WAKE = 6'h22, O_CLASS = 6'h23;

    typedef struct {
        logic       valid;
        logic [2:0] code;
        logic [2:0] st;
        logic [5:0] out;
        logic [7:0] wc;
    } vec_t;

    vec_t vecs[28];

    sleep_fsm_timed dut (
        .clk           (clk),
        .reset         (reset),
        .input_signal  (input_signal),
        .input_valid   (input_valid),
        .output_signal (output_signal),
        .state_out     (state_out),
        .timer_expired (timer_expired),
        .wake_count    (wake_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [2:0] st, input logic [5:0] out,
                              input logic te);
        check({name, " state"}, 32'(state_out), 32'(st));
        check({name, " output"}, 32'(output_signal), 32'(out));
        check({name, " timer_expired"}, 32'(timer_expired), 32'(te));
    endtask

    task automatic drive(input logic v, input logic [2:0] c);
        input_valid  = v;
        input_signal = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 3'b000);
        #2;
        step();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'b000, S_IDLE,  O_IDLE,  8'd0};
        vecs[1]  = '{1'b0, 3'b001, S_IDLE,  O_IDLE,  8'd0};
        vecs[2]  = '{1'b1, 3'b100, S_CLASS, O_CLASS, 8'd0};
        vecs[3]  = '{1'b0, 3'b111, S_CLASS, O_CLASS, 8'd0};
        vecs[4]  = '{1'b1, 3'b100, S_CLASS, O_CLASS, 8'd0};
        vecs[5]  = '{1'b1, 3'b011, S_HIB,   O_REST,  8'd0};
        vecs[6]  = '{1'b1, 3'b101, S_HIB,   O_REST,  8'd0};
        vecs[7]  = '{1'b1, 3'b110, S_HIB,   O_REST,  8'd0};
        vecs[8]  = '{1'b0, 3'b111, S_HIB,   O_REST,  8'd0};
        vecs[9]  = '{1'b1, 3'b111, S_WAKE,  O_WAKE,  8'd1};
        vecs[10] = '{1'b1, 3'b100, S_CLASS, O_CLASS, 8'd1};
        vecs[11] = '{1'b1, 3'b111, S_IDLE,  O_IDLE,  8'd1};
        vecs[12] = '{1'b1, 3'b001, S_NAP,   O_REST,  8'd1};
        vecs[13] = '{1'b1, 3'b011, S_NAP,   O_REST,  8'd1};
        vecs[14] = '{1'b1, 3'b100, S_WAKE,  O_WAKE,  8'd2};
        vecs[15] = '{1'b0, 3'b000, S_IDLE,  O_IDLE,  8'd2};
        vecs[16] = '{1'b1, 3'b010, S_SLEEP, O_REST,  8'd2};
        vecs[17] = '{1'b1, 3'b110, S_SLEEP, O_REST,  8'd2};
        vecs[18] = '{1'b1, 3'b100, S_SLEEP, O_REST,  8'd2};
        vecs[19] = '{1'b1, 3'b101, S_SLEEP, O_REST,  8'd2};
        vecs[20] = '{1'b0, 3'b101, S_SLEEP, O_REST,  8'd2};
        vecs[21] = '{1'b1, 3'b111, S_SLEEP, O_REST,  8'd2};
        vecs[22] = '{1'b1, 3'b101, S_WAKE,  O_WAKE,  8'd3};
        vecs[23] = '{1'b1, 3'b000, S_IDLE,  O_IDLE,  8'd3};
        vecs[24] = '{1'b1, 3'b100, S_CLASS, O_CLASS, 8'd3};
        vecs[25] = '{1'b1, 3'b001, S_NAP,   O_REST,  8'd3};
        vecs[26] = '{1'b1, 3'b111, S_WAKE,  O_WAKE,  8'd4};
        vecs[27] = '{1'b0, 3'b100, S_IDLE,  O_IDLE,  8'd4};

        // Reset state, observed before any clock edge.
        reset = 1'b1;
        drive(1'b0, 3'b000);
        #2;
        expect_out("reset", S_IDLE, O_IDLE, 1'b0);
        check("reset wake_count", 32'(wake_count), 32'd0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].valid, vecs[i].code);
            step();
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].out, 1'b0);
            check($sformatf("vec%0d wake_count", i), 32'(wake_count), 32'(vecs[i].wc));
        end

        // NAP timeout: 8 cycles in NAP, then WAKEUP with timer_expired, then IDLE.
        do_reset();
        drive(1'b1, 3'b001);
        step();
        drive(1'b0, 3'b000);
        expect_out("nap entry", S_NAP, O_REST, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step();
            expect_out($sformatf("nap dwell%0d", i), S_NAP, O_REST, 1'b0);
        end
        step();
        expect_out("nap timeout", S_WAKE, O_WAKE, 1'b1);
        check("nap timeout wake_count", 32'(wake_count), 32'd1);
        step();
        expect_out("nap after wake", S_IDLE, O_IDLE, 1'b0);

        // Input wake on the terminal-count cycle wins over timeout.
        drive(1'b1, 3'b001);
        step();
        drive(1'b0, 3'b000);
        for (int i = 1; i < 8; i++) step();
        expect_out("nap at t7", S_NAP, O_REST, 1'b0);
        drive(1'b1, 3'b101);
        step();
        expect_out("nap priority", S_WAKE, O_WAKE, 1'b0);
        drive(1'b0, 3'b000);
        step();

        // SLEEP timeout after 32 cycles.
        drive(1'b1, 3'b010);
        step();
        drive(1'b0, 3'b000);
        for (int i = 1; i < 32; i++) step();
        expect_out("sleep at t31", S_SLEEP, O_REST, 1'b0);
        step();
        expect_out("sleep timeout", S_WAKE, O_WAKE, 1'b1);
        step();

        // Debounced exit from SLEEP: one alarm cycle is not enough, two are.
        drive(1'b1, 3'b010);
        step();
        drive(1'b1, 3'b110);
        step();
        drive(1'b0, 3'b000);
        step();
        expect_out("sleep single alarm", S_SLEEP, O_REST, 1'b0);
        drive(1'b1, 3'b110);
        step();
        expect_out("sleep alarm 1", S_SLEEP, O_REST, 1'b0);
        step();
        expect_out("sleep alarm 2", S_WAKE, O_WAKE, 1'b0);
        drive(1'b0, 3'b000);
        step();

        // HIBERNATE ignores loud noise and alarms; only cold water wakes.
        drive(1'b1, 3'b011);
        step();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, (i % 2 == 0) ? 3'b101 : 3'b110);
            step();
        end
        expect_out("hib after 100", S_HIB, O_REST, 1'b0);
        drive(1'b1, 3'b111);
        step();
        expect_out("hib coldwater", S_WAKE, O_WAKE, 1'b0);
        drive(1'b1, 3'b100);
        step();
        expect_out("wake to class", S_CLASS, O_CLASS, 1'b0);

        // Asynchronous reset mid-SLEEP at timer 20, then a fresh NAP dwell.
        drive(1'b1, 3'b010);
        step();
        drive(1'b0, 3'b000);
        for (int i = 0; i < 20; i++) step();
        expect_out("sleep at t20", S_SLEEP, O_REST, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_out("async reset", S_IDLE, O_IDLE, 1'b0);
        check("async reset wake_count", 32'(wake_count), 32'd0);
        step();
        reset = 1'b0;
        drive(1'b1, 3'b001);
        step();
        expect_out("post reset nap", S_NAP, O_REST, 1'b0);
        drive(1'b0, 3'b000);
        for (int i = 1; i < 8; i++) step();
        expect_out("post reset nap t7", S_NAP, O_REST, 1'b0);
        step();
        expect_out("post reset timeout", S_WAKE, O_WAKE, 1'b1);
        step();

        // 300 forced wakes saturate the counter at 255.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'b001);
            step();
            drive(1'b1, 3'b101);
            step();
            drive(1'b0, 3'b000);
            step();
            if (i == 9) check("wake_count at 10", 32'(wake_count), 32'd10);
            if (i == 254) check("wake_count at 255", 32'(wake_count), 32'd255);
        end
        check("wake_count saturated", 32'(wake_count), 32'd255);
        expect_out("after wakes", S_IDLE, O_IDLE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
